// File: rtl/bank_sched_if.sv
// Producer write port and SPI block handoff of the bootstrap bank scheduler.
// The scheduler takes the slave side; the UART producer / SPI programmer take the master side.
interface bank_sched_if #(
   parameter int ADDR_BITS = 8
);
   logic                 wr_valid;
   logic                 wr_ready;
   logic                 wr_en;
   logic                 wr_bank;
   logic [ADDR_BITS-1:0] wr_addr;
   logic                 flush;
   logic                 blk_valid;
   logic                 blk_ready;
   logic                 blk_done;
   logic                 rd_bank;
   logic [ADDR_BITS:0]   blk_len;
   logic [23:0]          blk_addr;
   logic                 blk_last;
   logic                 fin;
   logic                 ovf;

   modport slave (
      input  wr_valid, flush, blk_ready, blk_done,
      output wr_ready, wr_en, wr_bank, wr_addr, blk_valid, rd_bank,
             blk_len, blk_addr, blk_last, fin, ovf
   );

   modport master (
      output wr_valid, flush, blk_ready, blk_done,
      input  wr_ready, wr_en, wr_bank, wr_addr, blk_valid, rd_bank,
             blk_len, blk_addr, blk_last, fin, ovf
   );
endinterface

// File: rtl/bank_sched.sv
// Ping-pong scheduler for the two bootstrap RAM banks: the UART producer fills one bank
// while the SPI page programmer drains the other, with flush-driven end-of-stream.
module bank_sched #(
   parameter int          BLOCK_SIZE = 256,
   parameter logic [23:0] BASE_ADDR  = 24'h000000
) (
   input  logic        clk,
   input  logic        rst,
   bank_sched_if.slave bus
);
   localparam int                   ADDR_BITS = $clog2(BLOCK_SIZE);
   localparam logic [ADDR_BITS-1:0] LAST_IDX  = ADDR_BITS'(BLOCK_SIZE - 1);
   localparam logic [23:0]          ADDR_STEP = 24'(BLOCK_SIZE);

   typedef enum logic [1:0] {EMPTY, FILL, FULL, BUSY} bank_state_t;

   bank_state_t          st_q   [2];
   bank_state_t          st_d   [2];
   logic [ADDR_BITS:0]   len_q  [2];
   logic [ADDR_BITS:0]   len_d  [2];
   logic                 last_q [2];
   logic                 last_d [2];
   logic [ADDR_BITS-1:0] count_q, count_d;
   logic                 wr_bank_q, wr_bank_d;
   logic                 rd_bank_q, rd_bank_d;
   logic [23:0]          blk_addr_q, blk_addr_d;
   logic                 flushed_q, flushed_d;
   logic                 fin_q, fin_d;
   logic                 ovf_q, ovf_d;

   logic                 other_bank;
   logic                 wr_ready;
   logic                 wr_en;
   logic                 flush_now;
   logic                 close;
   logic                 done_now;
   logic                 tail_pending;

   // Register every piece of bank bookkeeping; reset abandons any in-flight block.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q[0]    <= FILL;
         st_q[1]    <= EMPTY;
         len_q[0]   <= '0;
         len_q[1]   <= '0;
         last_q[0]  <= 1'b0;
         last_q[1]  <= 1'b0;
         count_q    <= '0;
         wr_bank_q  <= 1'b0;
         rd_bank_q  <= 1'b0;
         blk_addr_q <= BASE_ADDR;
         flushed_q  <= 1'b0;
         fin_q      <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         st_q       <= st_d;
         len_q      <= len_d;
         last_q     <= last_d;
         count_q    <= count_d;
         wr_bank_q  <= wr_bank_d;
         rd_bank_q  <= rd_bank_d;
         blk_addr_q <= blk_addr_d;
         flushed_q  <= flushed_d;
         fin_q      <= fin_d;
         ovf_q      <= ovf_d;
      end
   end

   // Fill-side close, flush handling, drain-side accept/done; these never touch the same bank field.
   always_comb begin
      st_d       = st_q;
      len_d      = len_q;
      last_d     = last_q;
      count_d    = count_q;
      wr_bank_d  = wr_bank_q;
      rd_bank_d  = rd_bank_q;
      blk_addr_d = blk_addr_q;
      flushed_d  = flushed_q;
      fin_d      = fin_q;
      ovf_d      = ovf_q;

      other_bank = ~wr_bank_q;
      wr_ready   = (st_q[wr_bank_q] == FILL) && !flushed_q;
      wr_en      = bus.wr_valid && wr_ready;
      flush_now  = bus.flush && !flushed_q;
      close      = (wr_en && (count_q == LAST_IDX)) ||
                   (flush_now && ((count_q != '0) || wr_en));
      done_now   = bus.blk_done && (st_q[rd_bank_q] == BUSY);
      // The most recently closed bank is the one not being filled; it counts only if still undone.
      tail_pending = (st_q[other_bank] == FULL) ||
                     ((st_q[other_bank] == BUSY) && !(done_now && (rd_bank_q == other_bank)));

      if (wr_en) begin
         count_d = count_q + ADDR_BITS'(1);
      end

      if (close) begin
         st_d[wr_bank_q]   = FULL;
         len_d[wr_bank_q]  = wr_en ? ({1'b0, count_q} + (ADDR_BITS+1)'(1)) : {1'b0, count_q};
         last_d[wr_bank_q] = flush_now;
         count_d           = '0;
         wr_bank_d         = other_bank;
         if ((st_q[other_bank] == EMPTY) && !flush_now) begin
            st_d[other_bank] = FILL;
         end
      end else if ((st_q[wr_bank_q] == EMPTY) && !flushed_q && !flush_now) begin
         st_d[wr_bank_q] = FILL;
      end

      if (flush_now) begin
         flushed_d = 1'b1;
         if (!close) begin
            if (tail_pending) begin
               last_d[other_bank] = 1'b1;
            end else begin
               fin_d = 1'b1;
            end
         end
      end

      if ((st_q[rd_bank_q] == FULL) && bus.blk_ready) begin
         st_d[rd_bank_q] = BUSY;
      end

      if (done_now) begin
         st_d[rd_bank_q]   = EMPTY;
         last_d[rd_bank_q] = 1'b0;
         blk_addr_d        = blk_addr_q + ADDR_STEP;
         rd_bank_d         = ~rd_bank_q;
         if (last_q[rd_bank_q]) begin
            fin_d = 1'b1;
         end
      end

      if (bus.wr_valid && !wr_ready && !flushed_q) begin
         ovf_d = 1'b1;
      end
   end

   assign bus.wr_ready  = wr_ready;
   assign bus.wr_en     = wr_en;
   assign bus.wr_bank   = wr_bank_q;
   assign bus.wr_addr   = count_q;
   assign bus.blk_valid = (st_q[rd_bank_q] == FULL);
   assign bus.rd_bank   = rd_bank_q;
   assign bus.blk_len   = len_q[rd_bank_q];
   assign bus.blk_addr  = blk_addr_q;
   assign bus.blk_last  = last_q[rd_bank_q];
   assign bus.fin       = fin_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_bank_sched.sv
// Directed bench for bank_sched: producer streams bytes, a simple SPI responder accepts
// blocks and pulses blk_done after a programmable delay, logging every block it handles.
module tb_bank_sched;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic        spi_auto;
   int          done_delay;
   int          busy_cnt;
   int          bytes_written;
   int          log_n;
   logic [23:0] log_addr [8];
   logic [8:0]  log_len  [8];
   logic        log_last [8];

   bank_sched_if #(.ADDR_BITS(8)) bus ();

   bank_sched dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic do_reset();
      rst           = 1'b1;
      bus.wr_valid  = 1'b0;
      bus.flush     = 1'b0;
      bus.blk_ready = 1'b0;
      bus.blk_done  = 1'b0;
      spi_auto      = 1'b0;
      done_delay    = 1;
      busy_cnt      = 0;
      bytes_written = 0;
      log_n         = 0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // One clock of producer + SPI responder; returns at posedge+1 with the new state visible.
   task automatic run_cycle(input logic valid, input logic fl);
      bus.wr_valid  = valid;
      bus.flush     = fl;
      bus.blk_ready = spi_auto;
      bus.blk_done  = 1'b0;
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) bus.blk_done = 1'b1;
      end
      #1;
      if (bus.blk_done && (log_n > 0)) log_last[log_n-1] = bus.blk_last;
      if (bus.blk_valid && bus.blk_ready && (log_n < 8)) begin
         log_addr[log_n] = bus.blk_addr;
         log_len[log_n]  = bus.blk_len;
         log_last[log_n] = 1'b0;
         log_n++;
         busy_cnt = done_delay;
      end
      if (bus.wr_en) bytes_written++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({bus.wr_ready, bus.wr_en, bus.wr_bank, bus.blk_valid, bus.rd_bank, bus.blk_last, bus.fin, bus.ovf} !== 8'b1000_0000) begin
         n_fail++;
         $display("[TB] FAIL reset_flags: got %b expected 10000000",
                  {bus.wr_ready, bus.wr_en, bus.wr_bank, bus.blk_valid, bus.rd_bank, bus.blk_last, bus.fin, bus.ovf});
      end
      n_checks++;
      if (bus.wr_addr !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_wr_addr: got %0d expected 0", bus.wr_addr); end
      n_checks++;
      if (bus.blk_len !== 9'd0) begin n_fail++; $display("[TB] FAIL reset_blk_len: got %0d expected 0", bus.blk_len); end
      n_checks++;
      if (bus.blk_addr !== 24'h000000) begin n_fail++; $display("[TB] FAIL reset_blk_addr: got %h expected 000000", bus.blk_addr); end
   endtask

   task automatic test_single_block();
      do_reset();
      spi_auto   = 1'b1;
      done_delay = 10;
      for (int i = 0; i < 256; i++) begin
         n_checks++;
         if (bus.wr_addr !== 8'(i)) begin n_fail++; $display("[TB] FAIL t1_wr_addr: got %0d expected %0d", bus.wr_addr, i); end
         run_cycle(1'b1, 1'b0);
      end
      n_checks++;
      if ({bus.blk_valid, bus.rd_bank, bus.wr_bank, bus.wr_ready} !== 4'b1011) begin
         n_fail++;
         $display("[TB] FAIL t1_close_flags: got %b expected 1011", {bus.blk_valid, bus.rd_bank, bus.wr_bank, bus.wr_ready});
      end
      n_checks++;
      if (bus.blk_len !== 9'd256) begin n_fail++; $display("[TB] FAIL t1_blk_len: got %0d expected 256", bus.blk_len); end
      repeat (5) run_cycle(1'b0, 1'b0);
      n_checks++;
      if ({bus.blk_valid, bus.blk_len} !== {1'b0, 9'd256}) begin
         n_fail++;
         $display("[TB] FAIL t1_busy_hold: got valid=%b len=%0d expected valid=0 len=256", bus.blk_valid, bus.blk_len);
      end
      repeat (10) run_cycle(1'b0, 1'b0);
      n_checks++;
      if ((log_n !== 1) || (log_addr[0] !== 24'd0) || (log_len[0] !== 9'd256)) begin
         n_fail++;
         $display("[TB] FAIL t1_block_log: got n=%0d addr=%0d len=%0d expected n=1 addr=0 len=256", log_n, log_addr[0], log_len[0]);
      end
      n_checks++;
      if ({bus.blk_addr, bus.rd_bank, bus.fin} !== {24'd256, 1'b1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL t1_after_done: got addr=%0d rd_bank=%b fin=%b expected addr=256 rd_bank=1 fin=0", bus.blk_addr, bus.rd_bank, bus.fin);
      end
   endtask

   task automatic test_stream_flush();
      do_reset();
      spi_auto   = 1'b1;
      done_delay = 1;
      repeat (600) run_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bytes_written, bus.ovf, bus.wr_addr} !== {32'd600, 1'b0, 8'd88}) begin
         n_fail++;
         $display("[TB] FAIL t2_stream: got bytes=%0d ovf=%b wr_addr=%0d expected 600 0 88", bytes_written, bus.ovf, bus.wr_addr);
      end
      run_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.blk_valid, bus.blk_len, bus.blk_last, bus.wr_ready} !== {1'b1, 9'd88, 1'b1, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL t2_flush_close: got valid=%b len=%0d last=%b wr_ready=%b expected 1 88 1 0",
                  bus.blk_valid, bus.blk_len, bus.blk_last, bus.wr_ready);
      end
      run_cycle(1'b0, 1'b0);
      n_checks++;
      if (bus.fin !== 1'b0) begin n_fail++; $display("[TB] FAIL t2_fin_early: got %b expected 0", bus.fin); end
      run_cycle(1'b0, 1'b0);
      n_checks++;
      if (bus.fin !== 1'b1) begin n_fail++; $display("[TB] FAIL t2_fin: got %b expected 1", bus.fin); end
      n_checks++;
      if ((log_n !== 3) || (log_addr[0] !== 24'd0) || (log_addr[1] !== 24'd256) || (log_addr[2] !== 24'd512)) begin
         n_fail++;
         $display("[TB] FAIL t2_addrs: got n=%0d %0d/%0d/%0d expected 3 0/256/512", log_n, log_addr[0], log_addr[1], log_addr[2]);
      end
      n_checks++;
      if ((log_len[0] !== 9'd256) || (log_len[1] !== 9'd256) || (log_len[2] !== 9'd88)) begin
         n_fail++;
         $display("[TB] FAIL t2_lens: got %0d/%0d/%0d expected 256/256/88", log_len[0], log_len[1], log_len[2]);
      end
      n_checks++;
      if ({log_last[0], log_last[1], log_last[2]} !== 3'b001) begin
         n_fail++;
         $display("[TB] FAIL t2_last: got %b%b%b expected 001", log_last[0], log_last[1], log_last[2]);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      repeat (512) run_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bus.wr_ready, bus.blk_valid, bus.ovf} !== 3'b010) begin
         n_fail++;
         $display("[TB] FAIL t3_stall: got wr_ready=%b valid=%b ovf=%b expected 0 1 0", bus.wr_ready, bus.blk_valid, bus.ovf);
      end
      run_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bytes_written, bus.ovf} !== {32'd512, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL t3_ovf: got bytes=%0d ovf=%b expected 512 1", bytes_written, bus.ovf);
      end
      spi_auto   = 1'b1;
      done_delay = 1;
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b0, 1'b0);
      n_checks++;
      if (bus.wr_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_freed_empty: got wr_ready=%b expected 0", bus.wr_ready); end
      run_cycle(1'b0, 1'b0);
      n_checks++;
      if (bus.wr_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL t3_resume: got wr_ready=%b expected 1", bus.wr_ready); end
      run_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bus.wr_addr, bus.wr_bank, bus.ovf} !== {8'd1, 1'b0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL t3_after_resume: got wr_addr=%0d wr_bank=%b ovf=%b expected 1 0 1", bus.wr_addr, bus.wr_bank, bus.ovf);
      end
   endtask

   task automatic test_flush_boundary();
      do_reset();
      spi_auto   = 1'b1;
      done_delay = 3;
      repeat (256) run_cycle(1'b1, 1'b0);
      run_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.blk_last, bus.blk_valid, bus.wr_ready} !== 3'b100) begin
         n_fail++;
         $display("[TB] FAIL t4_mark_last: got last=%b valid=%b wr_ready=%b expected 1 0 0", bus.blk_last, bus.blk_valid, bus.wr_ready);
      end
      run_cycle(1'b0, 1'b0);
      run_cycle(1'b0, 1'b0);
      n_checks++;
      if (bus.fin !== 1'b0) begin n_fail++; $display("[TB] FAIL t4_fin_early: got %b expected 0", bus.fin); end
      run_cycle(1'b0, 1'b0);
      n_checks++;
      if (bus.fin !== 1'b1) begin n_fail++; $display("[TB] FAIL t4_fin: got %b expected 1", bus.fin); end
      repeat (5) run_cycle(1'b0, 1'b0);
      n_checks++;
      if ((log_n !== 1) || (log_len[0] !== 9'd256) || (log_last[0] !== 1'b1) || (bus.fin !== 1'b1)) begin
         n_fail++;
         $display("[TB] FAIL t4_blocks: got n=%0d len=%0d last=%b fin=%b expected 1 256 1 1", log_n, log_len[0], log_last[0], bus.fin);
      end
   endtask

   task automatic test_empty_flush();
      do_reset();
      spi_auto = 1'b1;
      run_cycle(1'b0, 1'b1);
      n_checks++;
      if ({bus.fin, bus.blk_valid, bus.wr_ready} !== 3'b100) begin
         n_fail++;
         $display("[TB] FAIL t5_fin: got fin=%b valid=%b wr_ready=%b expected 1 0 0", bus.fin, bus.blk_valid, bus.wr_ready);
      end
      run_cycle(1'b1, 1'b0);
      run_cycle(1'b0, 1'b1);
      repeat (4) run_cycle(1'b0, 1'b0);
      n_checks++;
      if ({log_n, bytes_written, bus.ovf, bus.fin} !== {32'd0, 32'd0, 1'b0, 1'b1}) begin
         n_fail++;
         $display("[TB] FAIL t5_quiet: got blocks=%0d bytes=%0d ovf=%b fin=%b expected 0 0 0 1", log_n, bytes_written, bus.ovf, bus.fin);
      end
   endtask

   task automatic test_reset_midop();
      do_reset();
      spi_auto   = 1'b1;
      done_delay = 1;
      for (int i = 0; i < 612; i++) begin
         if (i == 300) done_delay = 1000;
         run_cycle(1'b1, 1'b0);
      end
      n_checks++;
      if ({bus.blk_addr, bus.rd_bank, bus.wr_addr, bus.blk_valid} !== {24'd256, 1'b1, 8'd100, 1'b0}) begin
         n_fail++;
         $display("[TB] FAIL t6_pre_reset: got addr=%0d rd_bank=%b wr_addr=%0d valid=%b expected 256 1 100 0",
                  bus.blk_addr, bus.rd_bank, bus.wr_addr, bus.blk_valid);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus.blk_addr, bus.rd_bank, bus.wr_addr, bus.wr_ready, bus.blk_len} !== {24'd0, 1'b0, 8'd0, 1'b1, 9'd0}) begin
         n_fail++;
         $display("[TB] FAIL t6_async_reset: got addr=%0d rd_bank=%b wr_addr=%0d wr_ready=%b len=%0d expected 0 0 0 1 0",
                  bus.blk_addr, bus.rd_bank, bus.wr_addr, bus.wr_ready, bus.blk_len);
      end
      do_reset();
      spi_auto = 1'b1;
      repeat (256) run_cycle(1'b1, 1'b0);
      repeat (3) run_cycle(1'b0, 1'b0);
      n_checks++;
      if ((log_n !== 1) || (log_addr[0] !== 24'd0) || (bus.blk_addr !== 24'd256)) begin
         n_fail++;
         $display("[TB] FAIL t6_restart: got n=%0d first_addr=%0d blk_addr=%0d expected 1 0 256", log_n, log_addr[0], bus.blk_addr);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      spi_auto   = 1'b1;
      done_delay = 255;
      repeat (512) run_cycle(1'b1, 1'b0);
      n_checks++;
      if ({bus.wr_ready, bus.blk_valid, bus.rd_bank, bus.wr_bank, bus.blk_addr} !== {1'b0, 1'b1, 1'b1, 1'b0, 24'd256}) begin
         n_fail++;
         $display("[TB] FAIL t7_close_and_done: got wr_ready=%b valid=%b rd_bank=%b wr_bank=%b addr=%0d expected 0 1 1 0 256",
                  bus.wr_ready, bus.blk_valid, bus.rd_bank, bus.wr_bank, bus.blk_addr);
      end
      run_cycle(1'b0, 1'b0);
      n_checks++;
      if ({bus.wr_ready, bus.wr_addr, bus.blk_len} !== {1'b1, 8'd0, 9'd256}) begin
         n_fail++;
         $display("[TB] FAIL t7_refill: got wr_ready=%b wr_addr=%0d len=%0d expected 1 0 256", bus.wr_ready, bus.wr_addr, bus.blk_len);
      end
   endtask

   initial begin
      test_reset();
      test_single_block();
      test_stream_flush();
      test_backpressure();
      test_flush_boundary();
      test_empty_flush();
      test_reset_midop();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
